// File: rtl/npc_trap_unit_pkg.sv
// rtl/npc_trap_unit_pkg.sv - shared encodings for the next-PC / trap unit
package npc_trap_unit_pkg;

  typedef enum logic [2:0] {
    NPC_PLUS4   = 3'd0,
    NPC_BRANCH  = 3'd1,
    NPC_JUMP    = 3'd2,
    NPC_JALR    = 3'd3,
    NPC_INT_RET = 3'd4
  } npc_op_e;

  localparam logic [3:0] EXC_ILLEGAL = 4'd1;
  localparam logic [3:0] EXC_ECALL   = 4'd2;

  // Cause register: bit 4 flags an interrupt, [3:0] is the exception code or irq index.
  typedef struct packed {
    logic       is_irq;
    logic [3:0] code;
  } cause_t;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - fixed-priority encoder, lowest set index wins
module irq_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [3:0]   idx
);

  always_comb begin
    valid = 1'b0;
    idx   = 4'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = 4'(i);
      end
    end
  end

endmodule

// File: rtl/npc_trap_unit.sv
// rtl/npc_trap_unit.sv - next-PC selection with interrupt/exception trap controller
module npc_trap_unit
  import npc_trap_unit_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              NUM_IRQ   = 8,
  parameter bit              VECTORED  = 1'b1,
  parameter logic [XLEN-1:0] TRAP_BASE = XLEN'(32'h0000_0040),
  parameter logic [XLEN-1:0] FAULT_VEC = XLEN'(32'h0800_0000)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [XLEN-1:0]    pc,
  input  logic [XLEN-1:0]    pc_ex,
  input  logic [2:0]         npc_op,
  input  logic [XLEN-1:0]    imm,
  input  logic [XLEN-1:0]    aluout,
  input  logic               pc_write,
  input  logic               exc_valid,
  input  logic [3:0]         exc_code,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               gie,
  output logic [XLEN-1:0]    npc,
  output logic               trap_taken,
  output logic               exl,
  output logic [XLEN-1:0]    epc,
  output logic [4:0]         cause,
  output logic               double_fault
);

  logic               exl_q, exl_d;
  logic               df_q, df_d;
  logic [XLEN-1:0]    epc_q, epc_d;
  cause_t             cause_q, cause_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] irq_hit, irq_ack;
  logic               irq_valid;
  logic [3:0]         irq_idx;
  logic               exc_take, irq_take, dbl_fault, trap_entry;
  logic [3:0]         trap_code;
  logic [XLEN-1:0]    trap_target;

  assign irq_hit = pend_q & irq_mask;

  irq_prio_enc #(.N(NUM_IRQ)) u_prio (
    .req   (irq_hit),
    .valid (irq_valid),
    .idx   (irq_idx)
  );

  assign exc_take    = pc_write & exc_valid;
  assign irq_take    = pc_write & gie & ~exl_q & irq_valid;
  assign dbl_fault   = exc_take & exl_q;
  assign trap_entry  = (exc_take | irq_take) & ~dbl_fault;
  assign trap_code   = exc_take ? exc_code : irq_idx;
  assign trap_target = VECTORED ? TRAP_BASE + (XLEN'(trap_code) << 2) : TRAP_BASE;

  // Only an accepted interrupt clears its pending bit; an exception in the same cycle defers it.
  always_comb begin
    irq_ack = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      irq_ack[i] = irq_take & ~exc_take & (irq_idx == 4'(i));
    end
  end

  always_comb begin
    npc = pc + XLEN'(4);
    if (!pc_write) begin
      npc = pc;
    end else if (dbl_fault) begin
      npc = FAULT_VEC;
    end else if (trap_entry) begin
      npc = trap_target;
    end else begin
      case (npc_op)
        NPC_BRANCH, NPC_JUMP: npc = pc_ex + imm;
        NPC_JALR:             npc = {aluout[XLEN-1:1], 1'b0};
        NPC_INT_RET:          npc = epc_q;
        default:              npc = pc + XLEN'(4);
      endcase
    end
  end

  always_comb begin
    exl_d   = exl_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    df_d    = df_q | dbl_fault;
    pend_d  = (pend_q | irq_req) & ~irq_ack;
    if (trap_entry) begin
      exl_d          = 1'b1;
      cause_d.is_irq = ~exc_take;
      cause_d.code   = trap_code;
      // Interrupts replay the killed EX instruction; exceptions resume after it.
      epc_d          = exc_take ? pc_ex + XLEN'(4) : pc_ex;
    end else if (pc_write && !dbl_fault && npc_op == NPC_INT_RET) begin
      exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exl_q   <= 1'b0;
      df_q    <= 1'b0;
      epc_q   <= '0;
      cause_q <= '0;
      pend_q  <= '0;
    end else begin
      exl_q   <= exl_d;
      df_q    <= df_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      pend_q  <= pend_d;
    end
  end

  assign trap_taken   = exc_take | irq_take;
  assign exl          = exl_q;
  assign epc          = epc_q;
  assign cause        = cause_q;
  assign double_fault = df_q;

endmodule

// File: doc/npc_trap_unit.md
Name: npc_trap_unit

Overview:
- Parametrised next-PC generator with an integrated trap controller. It supersedes the single-vector next-PC logic.
- Selects the fetch address for PC+4, branch, jump, JALR, trap entry and trap return.
- Adds per-source sticky interrupt pending and masking, fixed-priority arbitration, and vectored or direct trap targets.
- Holds exception-level (EXL), EPC and cause registers. Sits between the IF PC register and the EX stage.

Parameters:
- XLEN, 32, datapath and address width.
- NUM_IRQ, 8, number of interrupt sources (1..16).
- VECTORED, 1; 1 = target is TRAP_BASE + 4*cause, 0 = all traps go to TRAP_BASE.
- TRAP_BASE, 32'h0000_0040, trap vector base address.
- FAULT_VEC, 32'h0800_0000, double-fault target.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- pc  in  XLEN  current IF PC.
- pc_ex  in  XLEN  PC of instruction in EX.
- npc_op  in  3  shared NPC op: PLUS4, BRANCH, JUMP, JALR, INT_RET.
- imm  in  XLEN  branch/jump offset.
- aluout  in  XLEN  JALR target (bit 0 forced 0).
- pc_write  in  1  pipeline advance enable.
- exc_valid  in  1  synchronous exception from EX.
- exc_code  in  4  exception cause (ECALL=2, ILLEGAL=1).
- irq_req  in  NUM_IRQ  level interrupt requests.
- irq_mask  in  NUM_IRQ  per-source enable, 1 = enabled.
- gie  in  1  global interrupt enable.
- npc  out  XLEN  next PC.
- trap_taken  out  1  pulse; trap entry this cycle (flush IF/ID/EX).
- exl  out  1  exception level.
- epc  out  XLEN  saved return PC.
- cause  out  5  bit4 = interrupt flag, [3:0] = code.
- double_fault  out  1  sticky fault flag.

Behaviour:
- Reset (async, rstn=0): exl=0, epc=0, cause=0, pend=0, double_fault=0, trap_taken=0. npc remains combinational.
- Pending register `pend[i]` is set on any cycle with irq_req[i]=1. It is cleared only when source i is accepted. Set wins over clear only for sources not being accepted.
- `irq_hit` = pend & irq_mask. `irq_take` = pc_write & gie & ~exl & |irq_hit.
- Interrupt priority: the lowest index wins. The interrupt cause code equals the index.
- `exc_take` = pc_write & exc_valid.
  - Exceptions take priority over interrupts in the same cycle.
  - Exceptions are not masked by gie.
- Double fault: exc_take while exl=1.
  - npc=FAULT_VEC, double_fault set (sticky until reset), trap_taken=1.
  - epc, cause and exl are unchanged.
- Trap entry, combinational npc with registered updates at the clock edge:
  - npc = VECTORED ? TRAP_BASE + (cause_code<<2) : TRAP_BASE. trap_taken=1.
  - Next edge: exl<=1, cause<={is_irq, code}.
  - epc <= exception ? pc_ex+4 : pc_ex. An interrupt re-executes the killed EX instruction.
- INT_RET with pc_write and no trap this cycle: npc=epc; exl<=0 at the edge. INT_RET with exl=0 still jumps to epc and has no other effect.
- No trap: npc selection by npc_op.
  - PLUS4: pc+4.
  - BRANCH and JUMP: pc_ex+imm.
  - JALR: {aluout[XLEN-1:1],1'b0}.
  - Undefined codes: pc+4.
- pc_write=0: npc=pc, trap_taken=0, no state update except pend setting.
- All address arithmetic is modulo 2^XLEN and wraps silently.
- Reset asserted mid-trap abandons everything; the pending interrupts are lost.

Decomposition:
- Shared package or define file holds:
  - NPC op encodings, including INT_RET.
  - Exception code constants.
  - Cause field layout.
- Sub-module irq_prio_enc: a parametrised NUM_IRQ priority encoder with outputs valid and idx[3:0].

Test Plan:
- Sequencing: pc=0x100, npc_op PLUS4, then BRANCH with pc_ex=0xF8 and imm=0x20, then JALR with aluout=0x205 -> npc=0x104, then 0x118, then 0x204.
- Interrupt entry and return: gie=1, mask=0xFF, irq_req[3] pulsed one cycle, pc_ex=0x200.
  - Entry: npc=0x4C, trap_taken=1; next cycle exl=1, epc=0x200, cause=0x13, pend[3]=0.
  - INT_RET: npc=0x200, exl cleared.
- Same-cycle conflict: exc_valid with code 2 plus irq_req[0], pc_ex=0x300 -> npc=0x48, cause=0x02, epc=0x304; pend[0] stays 1 and is taken after return.
- Priority and masking: irq_req=0b1010 with mask=0b1000 -> source 3 taken. Same stimulus with gie=0 -> no trap, pend retained.
- Double fault: exc_valid while exl=1 -> npc=0x0800_0000, double_fault=1, epc unchanged. rstn low mid-cycle -> all state cleared asynchronously.
- Parameter sweep: VECTORED=0, XLEN=32, NUM_IRQ=16, irq 15 -> npc=TRAP_BASE, cause=0x1F. pc_write=0 -> npc=pc and no exl change.
